// File: rtl/serial_addsub_word_pkg.sv
// Shared types and elaboration-time helpers for the digit-serial add/subtract unit.
package serial_addsub_word_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

    function automatic int unsigned calc_ndig(input int unsigned width, input int unsigned digit);
        return width / digit;
    endfunction

    // Counter never narrower than one bit, even for single-step operation.
    function automatic int unsigned calc_cw(input int unsigned ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

    function automatic bit params_legal(input int unsigned width, input int unsigned digit);
        return (width >= 2) && (digit >= 1) && (digit <= width) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/serial_digit_adder.sv
// Combinational DIGIT-bit ripple adder; also exposes the carry into its top bit.
module serial_digit_adder #(
    parameter int unsigned DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    logic c;

    always_comb begin
        c     = cin;
        c_msb = cin;
        s     = '0;
        for (int unsigned i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) begin
                c_msb = c;
            end
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/serial_addsub_word.sv
// Digit-serial two's-complement add/subtract, LSB first, with start/busy/done handshake.
module serial_addsub_word
    import serial_addsub_word_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int unsigned NDIG = calc_ndig(WIDTH, DIGIT);
    localparam int unsigned CW   = calc_cw(NDIG);
    localparam logic [CW-1:0] LastCnt = CW'(NDIG - 1);

    if (!params_legal(WIDTH, DIGIT)) begin : g_param_check
        $error("serial_addsub_word: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             cout_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;

    logic [DIGIT-1:0] dig_s;
    logic             dig_cout;
    logic             dig_cmsb;
    logic [WIDTH-1:0] res_next;

    serial_digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit (
        .x     (a_q[DIGIT-1:0]),
        .y     (b_q[DIGIT-1:0]),
        .cin   (carry_q),
        .s     (dig_s),
        .cout  (dig_cout),
        .c_msb (dig_cmsb)
    );

    // New digit enters at the top; after NDIG shifts the word is LSB-aligned.
    always_comb begin
        res_next = (res_q >> DIGIT) | (WIDTH'(dig_s) << (WIDTH - DIGIT));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (enable) begin
                        a_q     <= a_q >> DIGIT;
                        b_q     <= b_q >> DIGIT;
                        res_q   <= res_next;
                        carry_q <= dig_cout;
                        cnt_q   <= cnt_q + 1'b1;
                        if (cnt_q == LastCnt) begin
                            sum_q   <= res_next;
                            cout_q  <= dig_cout;
                            ovf_q   <= dig_cmsb ^ dig_cout;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sum       = sum_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_addsub_word.sv
// Scoreboard bench: an 8-bit/1-bit-digit instance and a 16-bit/4-bit-digit instance.
module tb_serial_addsub_word;

    logic clk = 1'b0;
    logic reset = 1'b0;

    logic       en1, start1, sub1, busy1, done1, c1, v1;
    logic [7:0] a1, b1, s1;
    logic        en2, start2, sub2, busy2, done2, c2, v2;
    logic [15:0] a2, b2, s2;

    always #5 clk = ~clk;

    serial_addsub_word #(.WIDTH(8), .DIGIT(1)) u_dut8 (
        .clk(clk), .reset(reset), .enable(en1), .start(start1), .sub(sub1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .sum(s1), .carry_out(c1), .overflow(v1)
    );

    serial_addsub_word #(.WIDTH(16), .DIGIT(4)) u_dut16 (
        .clk(clk), .reset(reset), .enable(en2), .start(start2), .sub(sub2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .sum(s2), .carry_out(c2), .overflow(v2)
    );

    typedef struct {
        logic [15:0] sum;
        logic        c;
        logic        v;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int seen0 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain modular arithmetic plus sign-rule overflow.
    function automatic exp_t model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                   input logic sv);
        exp_t e;
        logic [16:0] full;
        logic [15:0] mask, bb;
        logic sa, sb, ss;
        mask  = 16'((17'h1 << w) - 17'h1);
        bb    = (sv ? ~bv : bv) & mask;
        full  = {1'b0, av & mask} + {1'b0, bb} + 17'(sv);
        e.sum = full[15:0] & mask;
        e.c   = full[w];
        sa    = av[w-1];
        sb    = bv[w-1];
        ss    = e.sum[w-1];
        e.v   = sv ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
        e.cyc = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (reset && done1) begin
            exp_t e;
            seen0++;
            if (q0.size() == 0) begin
                check("dut8 unexpected done", 1, 0);
            end else begin
                e = q0.pop_front();
                check("dut8 sum", 32'(s1), 32'(e.sum[7:0]));
                check("dut8 carry_out", 32'(c1), 32'(e.c));
                check("dut8 overflow", 32'(v1), 32'(e.v));
                check("dut8 done cycle", cyc, e.cyc);
                check("dut8 busy at done", 32'(busy1), 0);
            end
        end
    end

    always @(negedge clk) begin
        if (reset && done2) begin
            exp_t e;
            if (q1.size() == 0) begin
                check("dut16 unexpected done", 1, 0);
            end else begin
                e = q1.pop_front();
                check("dut16 sum", 32'(s2), 32'(e.sum));
                check("dut16 carry_out", 32'(c2), 32'(e.c));
                check("dut16 overflow", 32'(v2), 32'(e.v));
                check("dut16 done cycle", cyc, e.cyc);
            end
        end
    end

    function automatic logic get_busy(input int which);
        return (which == 0) ? busy1 : busy2;
    endfunction

    task automatic set_inputs(input int which, input logic st, input logic [15:0] av,
                              input logic [15:0] bv, input logic sv);
        if (which == 0) begin
            start1 = st; a1 = av[7:0]; b1 = bv[7:0]; sub1 = sv;
        end else begin
            start2 = st; a2 = av; b2 = bv; sub2 = sv;
        end
    endtask

    task automatic set_en(input int which, input logic v);
        if (which == 0) en1 = v;
        else en2 = v;
    endtask

    // Called and returns #1 after a rising edge. Starts as soon as the DUT is idle,
    // so consecutive calls exercise start-in-done-cycle.
    task automatic run_op(input int which, input logic [15:0] av, input logic [15:0] bv,
                          input logic sv, input int stall_at, input int stall_len,
                          input bit ghost);
        int n;
        int consumed;
        int nd;
        exp_t e;
        nd = (which == 0) ? 8 : 4;
        n = 0;
        while (get_busy(which) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle wait within bound", 32'(n < 200), 1);
        set_inputs(which, 1'b1, av, bv, sv);
        @(posedge clk);
        #1;
        e = model((which == 0) ? 8 : 16, av, bv, sv);
        e.cyc = cyc + nd + stall_len;
        if (which == 0) q0.push_back(e);
        else q1.push_back(e);
        consumed = 0;
        if (ghost) begin
            set_inputs(which, 1'b1, ~av, bv ^ 16'h5a5a, ~sv);
            @(posedge clk);
            #1;
            consumed = 1;
        end
        set_inputs(which, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
        if (stall_len > 0) begin
            repeat (stall_at - consumed) @(posedge clk);
            #1;
            set_en(which, 1'b0);
            repeat (stall_len) @(posedge clk);
            #1;
            set_en(which, 1'b1);
        end
    endtask

    initial begin
        int snap;
        int n;
        en1 = 1'b1; en2 = 1'b1;
        set_inputs(0, 1'b0, 16'h0, 16'h0, 1'b0);
        set_inputs(1, 1'b0, 16'h0, 16'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("reset sum", 32'(s1), 0);
        check("reset carry_out", 32'(c1), 0);
        check("reset overflow", 32'(v1), 0);
        check("reset busy", 32'(busy1), 0);
        check("reset done", 32'(done1), 0);
        @(posedge clk);
        #1;

        run_op(0, 16'h05, 16'h03, 1'b0, 0, 0, 1'b0);
        run_op(0, 16'h7F, 16'h01, 1'b0, 0, 0, 1'b0);
        run_op(0, 16'hFF, 16'h01, 1'b0, 0, 0, 1'b0);
        run_op(0, 16'h03, 16'h05, 1'b1, 0, 0, 1'b0);
        run_op(0, 16'h80, 16'h01, 1'b1, 0, 0, 1'b0);

        // Abort mid-run: outputs drop at once and the pending result never appears.
        run_op(0, 16'h05, 16'h03, 1'b0, 0, 0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("busy before abort", 32'(busy1), 1);
        reset = 1'b0;
        #1;
        check("abort busy", 32'(busy1), 0);
        check("abort done", 32'(done1), 0);
        check("abort sum", 32'(s1), 0);
        check("abort carry_out", 32'(c1), 0);
        check("abort overflow", 32'(v1), 0);
        q0.delete();
        snap = seen0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("no done after abort", seen0, snap);

        run_op(0, 16'h05, 16'h03, 1'b0, 0, 0, 1'b0);
        run_op(0, 16'h05, 16'h03, 1'b0, 2, 3, 1'b1);

        run_op(1, 16'h1234, 16'h0FCD, 1'b0, 0, 0, 1'b0);
        run_op(1, 16'h8000, 16'h0001, 1'b1, 0, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            int which;
            int sl;
            int sa;
            int nd;
            which = int'($urandom_range(0, 1));
            nd = (which == 0) ? 8 : 4;
            sl = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            sa = int'($urandom_range(1, nd - 1));
            run_op(which, 16'($urandom), 16'($urandom), 1'($urandom), sa, sl,
                   1'($urandom_range(0, 1)));
        end

        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("scoreboard drained", q0.size() + q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/serial_addsub_word.md
Name: serial_addsub_word

Overview:
- Parametrised successor to the team's single-bit serial two's-complement adder FSM.
- Adds or subtracts two WIDTH-bit two's-complement words LSB-first, processing DIGIT bits per enabled clock.
- Uses a start/busy/done handshake and reports carry and signed overflow.
- Sits between a register-file/operand source and a result sink wherever area matters more than latency.

Parameters:
- WIDTH, 8: operand and result width in bits. Must be at least 2.
- DIGIT, 1: bits processed per enabled cycle. Must divide WIDTH; DIGIT = WIDTH gives single-step operation.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low. 0 clears all state immediately, independent of clk.
- enable  in  1  when 0 in RUN, freezes all state (stall); ignored in IDLE.
- start  in  1  request a new operation; sampled only when busy = 0.
- sub  in  1  0 selects a+b, 1 selects a-b; captured with start.
- a  in  WIDTH  operand A, captured with start.
- b  in  WIDTH  operand B, captured with start.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when the result becomes valid.
- sum  out  WIDTH  result; held stable from done until the next accepted start.
- carry_out  out  1  carry out of the MSB; for sub, 1 means no borrow.
- overflow  out  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset values: sum = 0, carry_out = 0, overflow = 0, busy = 0, done = 0, state = IDLE, digit counter = 0.
- NDIG = WIDTH/DIGIT.
- Capture (IDLE, start = 1, edge 0):
  - Latch a and b into shift registers.
  - If sub = 1, latch ~b instead of b.
  - Initialise the carry register to sub.
  - Set counter = 0, busy = 1, go to RUN. The enable level is irrelevant at this edge.
- RUN, enabled edge:
  - Add the low DIGIT bits of A, the low DIGIT bits of B and the carry register.
  - Shift the DIGIT result bits into the top of the result register; shift A and B right by DIGIT.
  - Update the carry register; increment the counter.
- RUN, enable = 0: no register changes.
- Completion, on the enabled edge processing digit NDIG-1:
  - carry_out = final carry; overflow = carry into MSB XOR final carry.
  - done = 1 for exactly one cycle; busy = 0; return to IDLE.
  - sum becomes visible at the same edge.
- Latency: done is high in the cycle after the NDIG-th enabled edge following the capture edge. With no stalls this is NDIG cycles after capture.
- The internal result register may shift during RUN. The sum port is updated only at completion, so it never shows partial results.
- start while busy = 1 is ignored; no queueing.
- start in the cycle done is high is accepted normally, since busy = 0.
- sum, carry_out and overflow hold their values until the next completion; they are not cleared on start.
- Reset asserted mid-RUN: abort immediately, all outputs take reset values, and no done pulse is issued.
- Arithmetic is modulo 2^WIDTH; the operand sign is not extended.

Decomposition:
- Shared package:
  - State encoding IDLE/RUN (1-bit enum).
  - Functions/localparams for NDIG and counter width CW = max(1, clog2(NDIG)).
  - Parameter legality checks: WIDTH % DIGIT == 0, WIDTH ≥ 2.
- One natural sub-module, serial_digit_adder:
  - Combinational DIGIT-bit ripple adder.
  - Inputs: x, y, cin. Outputs: s, cout, and c_msb (carry into its top bit).
  - The top level uses c_msb from the last digit for overflow.

Test Plan:
- WIDTH=8, DIGIT=1, a=0x05, b=0x03, sub=0 → done 8 cycles after capture; sum=0x08, carry_out=0, overflow=0.
- a=0x7F, b=0x01, sub=0 → sum=0x80, overflow=1, carry_out=0. Then a=0xFF, b=0x01 → sum=0x00, carry_out=1, overflow=0.
- a=0x03, b=0x05, sub=1 → sum=0xFE, carry_out=0, overflow=0. Then a=0x80, b=0x01, sub=1 → sum=0x7F, carry_out=1, overflow=1.
- 0x05+0x03 with enable held low for 3 cycles mid-RUN → done at 11 cycles after capture, same result. A second start pulsed while busy produces no effect.
- Reset pulsed low at RUN cycle 4 → busy, done, sum, carry_out and overflow read 0 immediately; no done follows. A fresh start afterwards completes correctly.
- WIDTH=16, DIGIT=4, a=0x1234, b=0x0FCD, sub=0 → done after 4 cycles, sum=0x2201. Back-to-back start in the done cycle is accepted.
